// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit with HI/LO registers.
package muldiv_pkg;

   typedef enum logic [2:0] {
      MD_MULT  = 3'd0,
      MD_MULTU = 3'd1,
      MD_DIV   = 3'd2,
      MD_DIVU  = 3'd3,
      MD_MTHI  = 3'd4,
      MD_MTLO  = 3'd5
   } md_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2
   } md_state_t;

   function automatic logic md_is_muldiv(input md_op_t op_i);
      return (op_i == MD_MULT) || (op_i == MD_MULTU) ||
             (op_i == MD_DIV)  || (op_i == MD_DIVU);
   endfunction

   function automatic logic md_is_signed(input md_op_t op_i);
      return (op_i == MD_MULT) || (op_i == MD_DIV);
   endfunction

endpackage

// File: rtl/hilo_regs.sv
// HI/LO architectural register pair with independent write enables.
module hilo_regs #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_we_hi,
   input  logic             i_we_lo,
   input  logic [WIDTH-1:0] i_d_hi,
   input  logic [WIDTH-1:0] i_d_lo,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo
);

   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
      end else begin
         if (i_we_hi) r_hi <= i_d_hi;
         if (i_we_lo) r_lo <= i_d_lo;
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_hilo.sv
// Iterative radix-2 multiply/divide unit: WIDTH step cycles plus one sign-fix
// cycle, committing into its own HI/LO pair.
module muldiv_hilo
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int             CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   md_state_t          r_state;
   logic [CW-1:0]      r_cnt;
   logic [2*WIDTH-1:0] r_acc;
   logic [WIDTH-1:0]   r_opnd;
   logic               r_is_div;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_busy;
   logic               r_done;

   md_op_t             w_op;
   logic               w_is_div;
   logic               w_a_neg;
   logic               w_b_neg;
   logic [WIDTH-1:0]   w_a_mag;
   logic [WIDTH-1:0]   w_b_mag;

   assign w_op     = md_op_t'(op);
   assign w_is_div = (w_op == MD_DIV) || (w_op == MD_DIVU);
   assign w_a_neg  = md_is_signed(w_op) & a[WIDTH-1];
   assign w_b_neg  = md_is_signed(w_op) & b[WIDTH-1];
   assign w_a_mag  = w_a_neg ? -a : a;
   assign w_b_mag  = w_b_neg ? -b : b;

   // Multiply step: conditional add into the upper half, then shift right.
   logic [WIDTH:0]     w_madd;
   logic [2*WIDTH-1:0] w_mul_nxt;

   assign w_madd    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                      (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});
   assign w_mul_nxt = {w_madd, r_acc[WIDTH-1:1]};

   // Divide step: restoring; partial remainder in the upper half, quotient
   // bits shift into the lower half as dividend bits shift out.
   logic [WIDTH:0]     w_rsh;
   logic               w_dge;
   logic [WIDTH-1:0]   w_dsub;
   logic [2*WIDTH-1:0] w_div_nxt;

   assign w_rsh     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
   assign w_dge     = w_rsh >= {1'b0, r_opnd};
   assign w_dsub    = w_rsh[WIDTH-1:0] - r_opnd;
   assign w_div_nxt = {(w_dge ? w_dsub : w_rsh[WIDTH-1:0]),
                       r_acc[WIDTH-2:0], w_dge};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_acc    <= '0;
         r_opnd   <= '0;
         r_is_div <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && md_is_muldiv(w_op)) begin
                  r_state  <= ST_RUN;
                  r_busy   <= 1'b1;
                  r_cnt    <= '0;
                  r_is_div <= w_is_div;
                  r_acc    <= {{WIDTH{1'b0}}, (w_is_div ? w_a_mag : w_b_mag)};
                  r_opnd   <= w_is_div ? w_b_mag : w_a_mag;
                  // Divide-by-zero keeps the raw all-ones quotient unsigned.
                  r_neg_q  <= (w_a_neg ^ w_b_neg) & ~(w_is_div & ~|b);
                  r_neg_r  <= w_a_neg;
               end
            end
            ST_RUN: begin
               r_acc <= r_is_div ? w_div_nxt : w_mul_nxt;
               r_cnt <= r_cnt + CW'(1);
               if (r_cnt == LAST) r_state <= ST_FIX;
            end
            ST_FIX: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b1;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;
   logic [WIDTH-1:0]   w_res_hi;
   logic [WIDTH-1:0]   w_res_lo;
   logic               w_fix;
   logic               w_idle_wr;
   logic               w_we_hi;
   logic               w_we_lo;

   assign w_prod   = r_neg_q ? -r_acc : r_acc;
   assign w_quo    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
   assign w_res_hi = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
   assign w_res_lo = r_is_div ? w_quo : w_prod[WIDTH-1:0];

   assign w_fix     = (r_state == ST_FIX);
   assign w_idle_wr = (r_state == ST_IDLE) & start;
   assign w_we_hi   = w_fix | (w_idle_wr & (w_op == MD_MTHI));
   assign w_we_lo   = w_fix | (w_idle_wr & (w_op == MD_MTLO));

   hilo_regs #(.WIDTH(WIDTH)) u_hilo (
      .i_clk   (clk),
      .i_rst_n (reset),
      .i_we_hi (w_we_hi),
      .i_we_lo (w_we_lo),
      .i_d_hi  (w_fix ? w_res_hi : a),
      .i_d_lo  (w_fix ? w_res_lo : a),
      .o_hi    (hi),
      .o_lo    (lo)
   );

   assign busy = r_busy;
   assign done = r_done;

endmodule
